misaligned_store_split: RTL

MISALIGNED_STORE_SPLIT -- requirements
Module: misaligned_store_split

---
 rtl/misaligned_store_split_if.sv | 37 +++
 rtl/misaligned_store_split.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/misaligned_store_split_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | misaligned_store_split_if : store request / write beat bundle         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface misaligned_store_split_if #(
  parameter int WORDLEN = 64,
  parameter int PA_BITS = 56
);
  logic                   ReqValid;
  logic                   ReqReady;
  logic [2:0]             ReqSize;
  logic [PA_BITS-1:0]     ReqAdr;
  logic [WORDLEN-1:0]     ReqData;
  logic                   BeatValid;
  logic                   BeatReady;
  logic [PA_BITS-1:0]     BeatAdr;
  logic [WORDLEN-1:0]     BeatData;
  logic [WORDLEN/8-1:0]   BeatByteMask;
  logic                   BeatLast;
  logic                   BeatSecond;
  logic                   MisalignedErr;

  // Requester side: issues stores and sinks the resulting beats.
  modport master (
    output ReqValid, ReqSize, ReqAdr, ReqData, BeatReady,
    input  ReqReady, BeatValid, BeatAdr, BeatData, BeatByteMask,
           BeatLast, BeatSecond, MisalignedErr
  );

  modport slave (
    input  ReqValid, ReqSize, ReqAdr, ReqData, BeatReady,
    output ReqReady, BeatValid, BeatAdr, BeatData, BeatByteMask,
           BeatLast, BeatSecond, MisalignedErr
  );
endinterface
`default_nettype wire

// File: rtl/misaligned_store_split.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | misaligned_store_split : splits word-boundary-crossing stores into    |
// | two byte-masked beats. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module misaligned_store_split #(
  parameter int WORDLEN          = 64,
  parameter int PA_BITS          = 56,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  wire logic                clk,
  input  wire logic                resetn,
  misaligned_store_split_if.slave  bus
);

  localparam int         NB        = WORDLEN / 8;
  localparam int         OFFW      = $clog2(NB);
  localparam logic [1:0] MAX_SIZE  = 2'(OFFW);
  localparam logic       SPLIT_OK  = (ALLOW_MISALIGNED != 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [2*NB-1:0]      mask_q, mask_d;
  logic [2*WORDLEN-1:0] data_q, data_d;
  logic [PA_BITS-1:0]   adr_q, adr_d;
  logic                 cross_q, cross_d;
  logic                 err_q, err_d;

  logic [1:0]           size_eff;
  logic [OFFW-1:0]      off;
  logic [NB-1:0]        size_mask;
  logic [WORDLEN-1:0]   data_sized;
  logic [2*NB-1:0]      ext_mask;
  logic [2*WORDLEN-1:0] ext_data;
  logic                 req_cross;

  logic                 beat_valid;
  logic                 beat_last;
  logic                 beat_second;
  logic [NB-1:0]        beat_mask;
  logic [WORDLEN-1:0]   beat_data;
  logic [PA_BITS-1:0]   beat_adr;
  logic                 req_ready;

  logic                 accept;
  logic                 reject;
  logic                 load;

  // Only the low two size bits are meaningful.
  logic                 unused_size_msb;
  assign unused_size_msb = bus.ReqSize[2];

  // Request decode: lane-position mask and data across a double-width window.
  always_comb begin
    size_eff   = bus.ReqSize[1:0];
    if (size_eff > MAX_SIZE) begin
      size_eff = MAX_SIZE;
    end
    off        = bus.ReqAdr[OFFW-1:0];
    size_mask  = '0;
    data_sized = '0;
    for (int i = 0; i < NB; i++) begin
      size_mask[i] = (i < int'(32'd1 << size_eff));
      if (size_mask[i]) begin
        data_sized[8*i +: 8] = bus.ReqData[8*i +: 8];
      end
    end
    ext_mask  = {{NB{1'b0}}, size_mask} << off;
    ext_data  = {{WORDLEN{1'b0}}, data_sized} << {off, 3'b000};
    req_cross = |ext_mask[2*NB-1:NB];
  end

  assign accept = bus.ReqValid & req_ready;
  assign reject = accept & req_cross & ~SPLIT_OK;
  assign load   = accept & ~reject;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      adr_q   <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      adr_q   <= adr_d;
      cross_q <= cross_d;
      err_q   <= err_d;
    end
  end

  // Request capture; fields only change when a new store is taken.
  always_comb begin
    mask_d  = mask_q;
    data_d  = data_q;
    adr_d   = adr_q;
    cross_d = cross_q;
    err_d   = reject;
    if (load) begin
      mask_d  = ext_mask;
      data_d  = ext_data;
      adr_d   = {bus.ReqAdr[PA_BITS-1:OFFW], {OFFW{1'b0}}};
      cross_d = req_cross;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (bus.BeatReady) begin
          if (cross_q) begin
            state_d = S_BEAT1;
          end else begin
            state_d = load ? S_BEAT0 : S_IDLE;
          end
        end
      end
      S_BEAT1: begin
        if (bus.BeatReady) begin
          state_d = load ? S_BEAT0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    beat_valid  = (state_q != S_IDLE);
    beat_second = (state_q == S_BEAT1);
    beat_last   = (state_q == S_BEAT1) | ((state_q == S_BEAT0) & ~cross_q);
    if (state_q == S_BEAT1) begin
      beat_mask = mask_q[2*NB-1:NB];
      beat_data = data_q[2*WORDLEN-1:WORDLEN];
      beat_adr  = adr_q + PA_BITS'(NB);
    end else begin
      beat_mask = mask_q[NB-1:0];
      beat_data = data_q[WORDLEN-1:0];
      beat_adr  = adr_q;
    end
    req_ready = (state_q == S_IDLE) | (beat_valid & bus.BeatReady & beat_last);
  end

  assign bus.ReqReady      = req_ready;
  assign bus.BeatValid     = beat_valid;
  assign bus.BeatAdr       = beat_adr;
  assign bus.BeatData      = beat_data;
  assign bus.BeatByteMask  = beat_mask;
  assign bus.BeatLast      = beat_last;
  assign bus.BeatSecond    = beat_second;
  assign bus.MisalignedErr = err_q;

endmodule
`default_nettype wire
